vend_fsm_param: RTL and testbench
=================================

// Module: vend_fsm_param
// PURPOSE
//   Parametrised coin-operated vending controller, next generation of the 2-coin single-price vend FSM.
//   Accumulates credit from three coin denominations, vends once credit >= PRICE, and returns change
//   or a cancel refund as a greedy coin stream over a valid/ready dispenser handshake.
//   Sits between the coin acceptor front end and the product/coin dispenser drivers.
// PARAMETERS
//   CREDIT_W    8    width of credit register and all value arithmetic
//   VAL_A       5    value of coin code 2'b01 (smallest unit)
//   VAL_B       10   value of coin code 2'b10; multiple of VAL_A, > VAL_A
//   VAL_C       25   value of coin code 2'b11; multiple of VAL_A, > VAL_B
//   PRICE       15   product price; multiple of VAL_A, >0
//   MAX_CREDIT  100  credit ceiling; a coin that would exceed it is rejected
// PORTS
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   coin         in   2         00 none, 01 A, 10 B, 11 C; one coin per cycle
//   cancel       in   1         request refund of current credit (level, sampled per cycle)
//   vend         out  1         one-cycle product-dispense pulse
//   coin_reject  out  1         one-cycle pulse: coin returned unaccepted
//   credit       out  CREDIT_W  registered current credit
//   busy         out  1         high in VEND, CHANGE, REFUND
//   chg_valid    out  1         change coin offered
//   chg_coin     out  2         coin code offered (01/10/11), stable while chg_valid && !chg_ready
//   chg_ready    in   1         dispenser accepts chg_coin this cycle
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, credit=0, vend=0, coin_reject=0, chg_valid=0, chg_coin=0, busy=0.
//   States: IDLE, VEND, CHANGE, REFUND; all outputs registered.
//   IDLE: coin!=0 and credit+val<=MAX_CREDIT -> credit+=val next cycle; else coin_reject=1 next cycle.
//     cancel=1: any coin same cycle rejected; credit>0 -> REFUND, credit==0 -> stay IDLE.
//     Accepted coin making credit>=PRICE -> VEND (state and new credit same edge).
//   VEND: vend=1 for exactly this cycle; credit-=PRICE; credit>0 -> CHANGE else IDLE. Latency coin->vend 1 cycle.
//   CHANGE/REFUND: chg_coin = largest coin with value<=credit; chg_valid=1.
//     On chg_valid&&chg_ready: credit-=value of chg_coin; credit reaches 0 -> IDLE, chg_valid=0 next cycle.
//     chg_ready low: hold chg_valid/chg_coin/credit unchanged indefinitely.
//   Coins arriving in VEND/CHANGE/REFUND: coin_reject pulse, credit unchanged. cancel ignored outside IDLE.
//   Arithmetic unsigned CREDIT_W; sums formed CREDIT_W+1 wide for the ceiling compare; no wrap permitted.
//   Parameter legality (VAL ordering, multiples, MAX_CREDIT < 2**CREDIT_W, PRICE<=MAX_CREDIT) is an
//   elaboration-time check; greedy change always terminates at 0.
//   Reset mid-CHANGE/REFUND: remaining credit is discarded, outputs return to reset values immediately.
// CONFIGURATION
//   VM_SALES_CNT_EN defined: extra port vend_count out 16, reset 0, +1 per vend pulse, saturates 16'hFFFF.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING (defaults)
//   A then B -> vend=1 on cycle after B, credit 0, chg_valid never asserted.
//   C, chg_ready=1 -> vend pulse; next cycle chg_valid=1 chg_coin=10; then IDLE credit 0.
//   B, then cancel=1 -> REFUND, one chg_coin=10, credit 0, vend never asserted.
//   C with chg_ready=0 for 3 cycles -> chg_valid=1, chg_coin=10, credit=10 held stable; ready=1 -> credit 0.
//   Coin A during CHANGE -> coin_reject=1 one cycle, credit unaffected; credit 95 + coin C -> reject, credit 95.
//   rst=0 asynchronously during CHANGE -> chg_valid=0, credit=0, state IDLE before next clk edge.

Source files
------------

// File: rtl/vend_fsm_param.sv
// Parametrised coin vending controller: credit accumulation, vend pulse, greedy change/refund stream.
// Define VM_SALES_CNT_EN to add a saturating 16-bit vend_count output.
module vend_fsm_param #(
    parameter int CREDIT_W   = 8,
    parameter int VAL_A      = 5,
    parameter int VAL_B      = 10,
    parameter int VAL_C      = 25,
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                vend,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    input  logic                chg_ready
`ifdef VM_SALES_CNT_EN
    ,
    output logic [15:0]         vend_count
`endif
);

    if (VAL_A <= 0 || VAL_B <= VAL_A || VAL_C <= VAL_B ||
        (VAL_B % VAL_A) != 0 || (VAL_C % VAL_A) != 0 ||
        PRICE <= 0 || (PRICE % VAL_A) != 0 || PRICE > MAX_CREDIT ||
        MAX_CREDIT >= 2**CREDIT_W) begin : g_param_err
        $error("vend_fsm_param: illegal parameter set");
    end

    localparam logic [CREDIT_W-1:0] A_V     = CREDIT_W'(VAL_A);
    localparam logic [CREDIT_W-1:0] B_V     = CREDIT_W'(VAL_B);
    localparam logic [CREDIT_W-1:0] C_V     = CREDIT_W'(VAL_C);
    localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE,
        S_REFUND
    } state_t;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return A_V;
            2'b10:   return B_V;
            2'b11:   return C_V;
            default: return '0;
        endcase
    endfunction

    // Credit is always a multiple of VAL_A, so the smallest coin always fits.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= C_V)      return 2'b11;
        else if (amt >= B_V) return 2'b10;
        else                 return 2'b01;
    endfunction

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  vend_q, vend_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  busy_q, busy_d;
    logic                  chg_valid_q, chg_valid_d;
    logic [1:0]            chg_coin_q, chg_coin_d;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W-1:0]   remain;
    logic [CREDIT_W-1:0]   paid;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        chg_valid_d   = chg_valid_q;
        chg_coin_d    = chg_coin_q;
        coin_reject_d = (coin != 2'b00);
        sum           = {1'b0, credit_q} + {1'b0, coin_value(coin)};
        remain        = credit_q - PRICE_V;
        paid          = credit_q - coin_value(chg_coin_q);

        case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    if (credit_q != '0) begin
                        state_d     = S_REFUND;
                        chg_valid_d = 1'b1;
                        chg_coin_d  = greedy_coin(credit_q);
                    end
                end else if (coin != 2'b00 && sum <= MAX_W) begin
                    coin_reject_d = 1'b0;
                    credit_d      = sum[CREDIT_W-1:0];
                    if (sum >= PRICE_W) state_d = S_VEND;
                end
            end
            S_VEND: begin
                credit_d = remain;
                if (remain != '0) begin
                    state_d     = S_CHANGE;
                    chg_valid_d = 1'b1;
                    chg_coin_d  = greedy_coin(remain);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE, S_REFUND: begin
                if (chg_ready) begin
                    credit_d = paid;
                    if (paid == '0) begin
                        state_d     = S_IDLE;
                        chg_valid_d = 1'b0;
                    end else begin
                        chg_coin_d = greedy_coin(paid);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        vend_d = (state_d == S_VEND);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_q        <= vend_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
        end
    end

    assign vend        = vend_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;

`ifdef VM_SALES_CNT_EN
    logic [15:0] vend_count_q, vend_count_d;

    assign vend_count_d = (vend_q && vend_count_q != 16'hFFFF) ? vend_count_q + 16'd1 : vend_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vend_count_q <= 16'd0;
        else      vend_count_q <= vend_count_d;
    end

    assign vend_count = vend_count_q;
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Randomised bench for vend_fsm_param: default instance plus a PRICE=MAX_CREDIT=100 instance
// so the credit ceiling is reachable; both checked against a transaction-level model.
module tb_vend_fsm_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       cancel;
    logic       chg_ready;

    logic       o_vend[2];
    logic       o_rej[2];
    logic [7:0] o_credit[2];
    logic       o_busy[2];
    logic       o_cv[2];
    logic [1:0] o_cc[2];

    int checks = 0;
    int errors = 0;

    // Model: credit as a plain integer, a pending-vend flag, and the precomputed list of change coins.
    int m_credit[2];
    bit m_vend[2];
    bit m_rej[2];
    int m_q[2][32];
    int m_n[2];
    int m_i[2];

    always #5 clk = ~clk;

    vend_fsm_param dut0 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .vend(o_vend[0]), .coin_reject(o_rej[0]), .credit(o_credit[0]), .busy(o_busy[0]),
        .chg_valid(o_cv[0]), .chg_coin(o_cc[0]), .chg_ready(chg_ready)
    );

    vend_fsm_param #(.PRICE(100), .MAX_CREDIT(100)) dut1 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .vend(o_vend[1]), .coin_reject(o_rej[1]), .credit(o_credit[1]), .busy(o_busy[1]),
        .chg_valid(o_cv[1]), .chg_coin(o_cc[1]), .chg_ready(chg_ready)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int price_of(input int k);
        return (k == 0) ? 15 : 100;
    endfunction

    function automatic int value_of(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int code_of(input int v);
        return (v == 25) ? 3 : (v == 10) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_credit[k] = 0;
            m_vend[k]   = 0;
            m_rej[k]    = 0;
            m_n[k]      = 0;
            m_i[k]      = 0;
        end
    endtask

    task automatic fill_change(input int k);
        int amt;
        amt    = m_credit[k];
        m_n[k] = 0;
        m_i[k] = 0;
        while (amt > 0) begin
            if (amt >= 25)      m_q[k][m_n[k]] = 25;
            else if (amt >= 10) m_q[k][m_n[k]] = 10;
            else                m_q[k][m_n[k]] = 5;
            amt -= m_q[k][m_n[k]];
            m_n[k]++;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            bit paying;
            paying = !m_vend[k] && (m_i[k] < m_n[k]);
            check_val($sformatf("u%0d.vend", k), int'(o_vend[k]), int'(m_vend[k]));
            check_val($sformatf("u%0d.coin_reject", k), int'(o_rej[k]), int'(m_rej[k]));
            check_val($sformatf("u%0d.credit", k), int'(o_credit[k]), m_credit[k]);
            check_val($sformatf("u%0d.busy", k), int'(o_busy[k]), int'(m_vend[k] || paying));
            check_val($sformatf("u%0d.chg_valid", k), int'(o_cv[k]), int'(paying));
            if (paying)
                check_val($sformatf("u%0d.chg_coin", k), int'(o_cc[k]), code_of(m_q[k][m_i[k]]));
        end
    endtask

    task automatic model_step(input logic [1:0] c, input logic cn, input logic rdy);
        for (int k = 0; k < 2; k++) begin
            bit rej;
            int v;
            rej = 0;
            v   = value_of(c);
            if (m_vend[k]) begin
                m_vend[k]   = 0;
                m_credit[k] -= price_of(k);
                fill_change(k);
                rej = (c != 2'b00);
            end else if (m_i[k] < m_n[k]) begin
                if (rdy) begin
                    m_credit[k] -= m_q[k][m_i[k]];
                    m_i[k]++;
                end
                rej = (c != 2'b00);
            end else if (cn) begin
                rej = (c != 2'b00);
                if (m_credit[k] > 0) fill_change(k);
            end else if (c != 2'b00) begin
                if (m_credit[k] + v <= 100) begin
                    m_credit[k] += v;
                    if (m_credit[k] >= price_of(k)) m_vend[k] = 1;
                end else begin
                    rej = 1;
                end
            end
            m_rej[k] = rej;
        end
    endtask

    task automatic step(input logic [1:0] c, input logic cn, input logic rdy);
        @(negedge clk);
        check_outputs();
        coin      = c;
        cancel    = cn;
        chg_ready = rdy;
        model_step(c, cn, rdy);
    endtask

    initial begin
        rst       = 1'b0;
        coin      = 2'b00;
        cancel    = 1'b0;
        chg_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // A then B: vend with exact price
        step(2'b01, 0, 1);
        step(2'b10, 0, 1);
        step(2'b00, 0, 1);
        step(2'b00, 0, 1);
        // C with ready: one change coin of 10
        step(2'b11, 0, 1);
        repeat (4) step(2'b00, 0, 1);
        // B then cancel: refund
        step(2'b10, 0, 1);
        step(2'b00, 1, 1);
        repeat (3) step(2'b00, 0, 1);
        // C with ready held low, coin A during CHANGE rejected, then release
        step(2'b11, 0, 0);
        step(2'b00, 0, 0);
        step(2'b01, 0, 0);
        step(2'b00, 0, 0);
        step(2'b00, 0, 1);
        repeat (3) step(2'b00, 0, 1);
        // climb the PRICE=100 instance to 95 then offer C (ceiling reject)
        repeat (9) step(2'b10, 0, 1);
        step(2'b01, 0, 1);
        step(2'b11, 0, 1);
        step(2'b00, 0, 1);
        step(2'b01, 0, 1);
        repeat (4) step(2'b00, 0, 1);

        // async reset while paying out change
        step(2'b11, 0, 0);
        step(2'b00, 0, 0);
        step(2'b00, 0, 0);
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("u%0d.rst_chg_valid", k), int'(o_cv[k]), 0);
            check_val($sformatf("u%0d.rst_credit", k), int'(o_credit[k]), 0);
            check_val($sformatf("u%0d.rst_busy", k), int'(o_busy[k]), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            logic [1:0] c;
            logic       cn;
            logic       rdy;
            c   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cn  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(c, cn, rdy);
        end
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
